// File: rtl/xoro_pkg.sv
// Shared register map and field layout for the UART receive peripheral.
package xoro_pkg;

    localparam int unsigned DATA_W = 8;

    // Register byte offsets; only address bit 2 is decoded.
    localparam logic [31:0] UART_RX_DATA     = 32'h0000_0000;
    localparam logic [31:0] UART_RX_STATUS   = 32'h0000_0004;
    localparam int unsigned UART_RX_ADDR_BIT = 2;

    // STATUS register bit indices.
    localparam int unsigned STAT_AVAIL   = 0;
    localparam int unsigned STAT_OVERRUN = 1;
    localparam int unsigned STAT_FRAMING = 2;

    // STATUS payload, MSB first so that it packs to {FRAMING, OVERRUN, AVAIL}.
    typedef struct packed {
        logic framing;
        logic overrun;
        logic avail;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; push is dropped when full unless a pop shares the cycle.
module uart_rx_fifo
    import xoro_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign dout  = mem_q[rd_q];

    // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a byte FIFO with sticky error flags.
module uart_rx
    import xoro_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        serialIn,
    output logic        rx_avail
);

    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              sync1_q, sync2_q;
    logic              framing_q, framing_d;
    logic              overrun_q, overrun_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pop_pend_q, pop_pend_d;

    logic              rx;
    logic              push_c;
    logic              frame_err_c;
    logic              req_c;
    logic              is_status;
    logic              is_write;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    uart_rx_status_t   status;
    logic              unused_ok;

    assign unused_ok = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:3], mem_wdata[0]};

    assign rx        = sync2_q;
    assign mem_ready = ready_q;
    assign mem_rdata = enable ? rdata_q : 32'h0;
    assign rx_avail  = !fifo_empty;

    // Line synchroniser, parked at the idle level on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serialIn;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM: half-bit start qualification, then centre sampling of data and stop bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_c      = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx) begin
                    state_d = ST_START;
                    cnt_d   = CNT_W'(HALF - 1);
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'(DIV - 1);
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rx, shift_q[DATA_W-1:1]};
                    cnt_d   = CNT_W'(DIV - 1);
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    push_c      = rx;
                    frame_err_c = !rx;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus decode: register read data and pop intent at request, pop in the ready cycle.
    always_comb begin
        req_c          = mem_valid && enable && !ready_q;
        is_status      = mem_addr[UART_RX_ADDR_BIT];
        is_write       = |mem_wstrb;
        status.framing = framing_q;
        status.overrun = overrun_q;
        status.avail   = !fifo_empty;
        ready_d        = req_c;
        rdata_d        = 32'h0;
        pop_pend_d     = 1'b0;
        framing_d      = framing_q;
        overrun_d      = overrun_q;
        if (req_c && !is_write) begin
            if (is_status) begin
                rdata_d = 32'(status);
            end else if (!fifo_empty) begin
                rdata_d    = {24'h0, fifo_dout};
                pop_pend_d = 1'b1;
            end
        end
        if (req_c && is_write && is_status) begin
            if (mem_wdata[STAT_FRAMING]) framing_d = 1'b0;
            if (mem_wdata[STAT_OVERRUN]) overrun_d = 1'b0;
        end
        if (frame_err_c)                         framing_d = 1'b1;
        if (push_c && fifo_full && !pop_pend_q)  overrun_d = 1'b1;
    end

    // State, datapath and bus registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            framing_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            pop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            framing_q  <= framing_d;
            overrun_q  <= overrun_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            pop_pend_q <= pop_pend_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (shift_q),
        .pop   (pop_pend_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
